// File: rtl/dist_rom_pkg.sv
// Shared constants and the content function for the 64-word "addi" ROM.
// Used by dist_rom_array (contents) and dist_rom_sync (default widths).
package dist_rom_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    // "addi x(index mod 32), x0, index" -- rd takes only the low five index bits.
    function automatic logic [31:0] rom_word(input int unsigned index);
        logic [5:0] w_idx;
        w_idx = 6'(index);
        return {6'b000000, w_idx, 5'b00000, FUNCT3_ADDI, w_idx[4:0], OP_IMM};
    endfunction

endpackage

// File: rtl/dist_rom_array.sv
// Combinational read-only array: maps an address to its content word.
// Contents are fixed at elaboration from rom_word; there is no write path.
module dist_rom_array
    import dist_rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_word
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_rom [DEPTH];

    // Size cast truncates or zero-extends the 32-bit word to DATA_W.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign w_rom[gi] = DATA_W'(rom_word(gi));
    end

    assign o_word = w_rom[i_addr];

endmodule

// File: rtl/dist_rom_sync.sv
// Distributed ROM with a registered, clock-enabled output (qspo).
// Define DIST_ROM_SPO_EN to also expose the asynchronous read port spo.
module dist_rom_sync
    import dist_rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a,
    input  logic              qspo_ce,
    output logic [DATA_W-1:0] qspo
`ifdef DIST_ROM_SPO_EN
    ,
    output logic [DATA_W-1:0] spo
`endif
);

    logic [DATA_W-1:0] w_word;
    // Initialiser gives a defined 0 before the first reset or enabled edge.
    logic [DATA_W-1:0] r_qspo = '0;

    dist_rom_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .i_addr (a),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qspo <= '0;
        end else if (qspo_ce) begin
            r_qspo <= w_word;
        end
    end

    assign qspo = r_qspo;

`ifdef DIST_ROM_SPO_EN
    assign spo = w_word;
`endif

endmodule

// File: tb/tb_dist_rom_sync.sv
// Directed and random checks of dist_rom_sync; expected qspo values are
// queued when stimulus is applied and popped one edge later for comparison.
module tb_dist_rom_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  a = 6'd5;
    logic        qspo_ce = 1'b0;
    logic [31:0] qspo;
`ifdef DIST_ROM_SPO_EN
    logic [31:0] spo;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] model_q = 32'h0;

    dist_rom_sync #(
        .ADDR_W (6),
        .DATA_W (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .qspo_ce (qspo_ce),
        .qspo    (qspo)
`ifdef DIST_ROM_SPO_EN
        ,
        .spo     (spo)
`endif
    );

    always #5 clk = ~clk;

    // Independent arithmetic model of the ROM contents.
    function automatic logic [31:0] model_word(input int unsigned i);
        return (i << 20) + ((i % 32) << 7) + 32'h13;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic r, input logic ce, input logic [5:0] addr, input string tag);
        logic [31:0] e;
        string       t;
        rst     = r;
        qspo_ce = ce;
        a       = addr;
        if (r)       model_q = 32'h0;
        else if (ce) model_q = model_word(addr);
        exp_q.push_back(model_q);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, qspo, e);
    endtask

    initial begin
        logic [5:0]  ra;
        logic        rce;
        logic [31:0] held;

        // Power-up value with neither reset nor enable.
        #1;
        check("powerup_t0", qspo, 32'h0);
        step(1'b0, 1'b0, 6'd5, "powerup_hold");

        // Reset overrides ce for two edges, then a=5 loads.
        step(1'b1, 1'b1, 6'd5, "reset_0");
        step(1'b1, 1'b1, 6'd5, "reset_1");
        step(1'b0, 1'b1, 6'd5, "post_reset_a5");
        check("const_a5", qspo, 32'h00500293);

        // Sequential sweep 0..16.
        for (int i = 0; i <= 16; i++) begin
            step(1'b0, 1'b1, 6'(i), $sformatf("sweep_a%0d", i));
            if (i == 0) check("const_a0", qspo, 32'h00000013);
        end
        check("const_a16", qspo, 32'h01000813);

        // Enable hold: address changes with ce low do not reach qspo.
        step(1'b0, 1'b1, 6'd1, "hold_load_a1");
        check("const_a1", qspo, 32'h00100093);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 6'd33, $sformatf("hold_ce0_%0d", i));
        check("hold_value", qspo, 32'h00100093);
        step(1'b0, 1'b1, 6'd33, "hold_release_a33");
        check("const_a33", qspo, 32'h02100093);

        // Boundaries.
        step(1'b0, 1'b1, 6'd63, "bound_a63");
        check("const_a63", qspo, 32'h03F00F93);
        step(1'b0, 1'b1, 6'd32, "bound_a32");
        check("const_a32", qspo, 32'h02000013);

        // Reset pulse mid-stream.
        step(1'b0, 1'b1, 6'd62, "prio_a62");
        step(1'b1, 1'b1, 6'd63, "prio_reset");
        check("prio_zero", qspo, 32'h0);
        step(1'b0, 1'b1, 6'd63, "prio_resume");
        check("prio_const_a63", qspo, 32'h03F00F93);

`ifdef DIST_ROM_SPO_EN
        // spo follows a immediately, qspo waits for an enabled edge.
        held = qspo;
        qspo_ce = 1'b0;
        a = 6'd5;
        #1;
        check("spo_a5", spo, 32'h00500293);
        check("spo_qspo_held", qspo, held);
        for (int i = 0; i < 8; i++) begin
            a = 6'($urandom_range(0, 63));
            #1;
            check($sformatf("spo_rand_a%0d", a), spo, model_word(a));
        end
        step(1'b0, 1'b0, 6'd5, "spo_ce0_edge");
`else
        held = 32'h0;
`endif

        // Random mix of enable, reset and address.
        for (int i = 0; i < 40; i++) begin
            ra  = 6'($urandom_range(0, 63));
            rce = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 9) == 0), rce, ra, $sformatf("rand_%0d_a%0d", i, ra));
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
